// File: rtl/mem_line_responder.sv
// mem_line_responder
//
// Main-memory model at the far end of the cache-fill interface. It serves
// line reads for the instruction-cache controller and line reads/writes
// (writebacks) for the data-cache controller. One transaction is in flight
// at a time, and each one takes a fixed LATENCY cycles from acceptance to
// its ready pulse.
//
// Ports:
//   clock, reset         rising-edge clock; synchronous active-high reset
//   i_req, i_addr        I-side line read request and byte address
//   i_rdata, i_ready     I-side returned line and one-cycle completion pulse
//   d_req, d_we, d_addr  D-side request, write flag and byte address
//   d_wdata              D-side write line
//   d_rdata, d_ready     D-side returned line (old line on writes) and pulse
//   busy                 a transaction is in flight (BUSY or RESP)
//   dbg_state            current FSM state, for checkers and debug
//
// Handshake: a requester raises req and holds it until its ready pulse.
// The request is sampled only in IDLE, and address, we and wdata are latched
// on that edge. Later changes, including dropping req, have no effect on the
// accepted transaction. ready is high for exactly one cycle (RESP), and rdata
// is valid in that cycle. A req still high when the FSM is back in IDLE
// counts as a new request.
//
// Configuration macro: MEM_LINE_RESPONDER_RR_EN
//   undefined: fixed priority, D over I
//   defined:   round-robin on conflicts using a one-bit last-grant register
//
// Line storage has no reset. Unwritten lines read as X in simulation.

module mem_line_responder #(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 32,
    parameter int LINES     = 1024,
    parameter int LATENCY   = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int CNT_W    = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_d_q;      // 1: D-side owns the transaction
    logic                  we_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [LINE_BITS-1:0]  i_rdata_q;
    logic [LINE_BITS-1:0]  d_rdata_q;
    logic [LINE_BITS-1:0]  mem_q [LINES];

    logic                  accept;
    logic                  load_rdata;
    logic                  pick_d;
    logic [IDX_BITS-1:0]   i_idx;
    logic [IDX_BITS-1:0]   d_idx;

    // Byte offset within the line is dropped. Bits above the index alias
    // modulo LINES.
    assign i_idx = i_addr[OFF_BITS +: IDX_BITS];
    assign d_idx = d_addr[OFF_BITS +: IDX_BITS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[OFF_BITS-1:0], i_addr[ADDR_BITS-1:OFF_BITS+IDX_BITS],
                                d_addr[OFF_BITS-1:0], d_addr[ADDR_BITS-1:OFF_BITS+IDX_BITS]};

`ifdef MEM_LINE_RESPONDER_RR_EN
    // last_d_q is 1 when D was the last port granted. It resets to I, so
    // the first conflict goes to D.
    logic last_d_q;

    assign pick_d = d_req & (~i_req | ~last_d_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else if (accept) begin
            last_d_q <= pick_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    // Next-state logic. The counter is loaded with LATENCY-1 on acceptance.
    // BUSY leaves when the count reaches 1, so BUSY lasts LATENCY-1 cycles
    // and the RESP cycle is the LATENCY-th cycle after the accepting edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d    = RESP;
                    load_rdata = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_d_q <= 1'b0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                grant_d_q <= pick_d;
                we_q      <= pick_d & d_we;
                idx_q     <= pick_d ? d_idx : i_idx;
                wdata_q   <= d_wdata;
            end
            // The line is read on the edge into RESP, one edge before any
            // write lands, so a writeback returns the old line.
            if (load_rdata) begin
                if (grant_d_q) begin
                    d_rdata_q <= mem_q[idx_q];
                end else begin
                    i_rdata_q <= mem_q[idx_q];
                end
            end
        end
    end

    // Storage has no reset. A reset on the RESP edge cancels the write.
    always_ff @(posedge clock) begin
        if (!reset && state_q == RESP && grant_d_q && we_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign i_ready   = (state_q == RESP) && !grant_d_q;
    assign d_ready   = (state_q == RESP) && grant_d_q;
    assign busy      = (state_q != IDLE);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder. Cycle numbering: cyc counts rising edges.
// A request driven after edge c is accepted at edge c+1. Its ready is seen
// at the falling edge where cyc == c + LATENCY.
module tb_mem_line_responder;

    localparam int LINE_BITS = 128;
    localparam int ADDR_BITS = 32;
    localparam int LINES     = 1024;
    localparam int LATENCY   = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 i_req;
    logic [ADDR_BITS-1:0] i_addr;
    logic [LINE_BITS-1:0] i_rdata;
    logic                 i_ready;
    logic                 d_req;
    logic                 d_we;
    logic [ADDR_BITS-1:0] d_addr;
    logic [LINE_BITS-1:0] d_wdata;
    logic [LINE_BITS-1:0] d_rdata;
    logic                 d_ready;
    logic                 busy;
    logic [1:0]           dbg_state;

    mem_line_responder #(
        .LINE_BITS(LINE_BITS), .ADDR_BITS(ADDR_BITS), .LINES(LINES), .LATENCY(LATENCY)
    ) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic                 port_d;
        logic                 chk;
        logic [31:0]          due;
        logic [LINE_BITS-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                         input logic [LINE_BITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic port_d, input logic chk, input int due,
                            input logic [LINE_BITS-1:0] data);
        exp_t e;
        e.port_d = port_d;
        e.chk    = chk;
        e.due    = 32'(due);
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (i_ready && d_ready) begin
                check("both_ready", 1, 0);
            end else if (i_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {127'd0, d_ready}, {127'd0, i_ready});
                    if (!d_ready) check("unexpected_ready", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ready_port", {127'd0, d_ready}, {127'd0, e.port_d});
                    check("ready_cycle", 128'(cyc), 128'(e.due));
                    if (e.chk) check("rdata", d_ready ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic wait_ready(input logic is_d, input int base_c, input logic chk_busy);
        logic got;
        got = 0;
        for (int n = 0; n < LATENCY + 12 && !got; n++) begin
            @(negedge clock);
            if (chk_busy) check("busy_inflight", {127'd0, busy}, {127'd0, cyc >= base_c + 1});
            if (is_d ? d_ready : i_ready) got = 1;
        end
        if (!got) begin
            check("ready_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic do_txn(input logic is_d, input logic we, input logic [ADDR_BITS-1:0] addr,
                          input logic [LINE_BITS-1:0] wdata, input logic [LINE_BITS-1:0] exp_data,
                          input logic chk);
        int c;
        @(posedge clock); #1;
        c = cyc;
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1; i_addr = addr;
        end
        push_exp(is_d, chk, c + LATENCY, exp_data);
        wait_ready(is_d, c, 1'b1);
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        check("busy_after", {127'd0, busy}, 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic                 is_d;
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] wdata;
        logic [LINE_BITS-1:0] exp_data;
        logic                 chk;
    } vec_t;

    localparam logic [LINE_BITS-1:0] L4  = 128'h4;
    localparam logic [LINE_BITS-1:0] A5  = {16{8'hA5}};
    localparam logic [LINE_BITS-1:0] V5A = {16{8'h5A}};
    localparam logic [LINE_BITS-1:0] V8  = {4{32'h8888_0008}};
    localparam logic [LINE_BITS-1:0] V8B = {4{32'hDEAD_BEEF}};

    vec_t vecs[9];

    initial begin
        int c;
        logic got;

        vecs[0] = '{1'b1, 1'b1, 32'h0000_0040, L4,  '0,  1'b0}; // preload line 4
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0040, '0,  L4,  1'b1}; // I read line 4
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, A5,  '0,  1'b0}; // write line 16
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, '0,  A5,  1'b1}; // read it back
        vecs[4] = '{1'b0, 1'b0, 32'h0000_4040, '0,  L4,  1'b1}; // alias of line 4
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0080, V8,  '0,  1'b0}; // preload line 8
        vecs[6] = '{1'b1, 1'b1, 32'h0000_010C, V5A, A5,  1'b1}; // write returns old line
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0100, '0,  V5A, 1'b1}; // new line visible
        vecs[8] = '{1'b1, 1'b0, 32'h0000_4084, '0,  V8,  1'b1}; // alias of line 8

        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_i_ready", {127'd0, i_ready}, 0);
        check("rst_d_ready", {127'd0, d_ready}, 0);
        check("rst_busy", {127'd0, busy}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_state", {126'd0, dbg_state}, 0);

        for (int v = 0; v < 9; v++) begin
            do_txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                   vecs[v].exp_data, vecs[v].chk);
        end

        // Conflict: D wins first, I follows one LATENCY+1 period later.
        @(posedge clock); #1;
        c = cyc;
        d_req = 1; d_we = 0; d_addr = 32'h40;
        i_req = 1; i_addr = 32'h80;
        push_exp(1'b1, 1'b1, c + LATENCY, L4);
        push_exp(1'b0, 1'b1, c + 2 * (LATENCY + 1) - 1, V8);
        wait_ready(1'b1, c, 1'b0);
        @(posedge clock); #1 d_req = 0;
        wait_ready(1'b0, c, 1'b0);
        @(posedge clock); #1 idle_inputs();
        @(negedge clock);

`ifdef MEM_LINE_RESPONDER_RR_EN
        // Both held across two more conflicts: D, I, D.
        @(posedge clock); #1;
        c = cyc;
        d_req = 1; d_we = 0; d_addr = 32'h40;
        i_req = 1; i_addr = 32'h80;
        push_exp(1'b1, 1'b1, c + LATENCY, L4);
        push_exp(1'b0, 1'b1, c + 2 * (LATENCY + 1) - 1, V8);
        push_exp(1'b1, 1'b1, c + 3 * (LATENCY + 1) - 1, L4);
        wait_ready(1'b1, c, 1'b0);
        wait_ready(1'b0, c, 1'b0);
        @(posedge clock); #1 i_req = 0;
        wait_ready(1'b1, c, 1'b0);
        @(posedge clock); #1 idle_inputs();
        @(negedge clock);
`endif

        // Inputs change and req drops during BUSY: latched read still completes.
        @(posedge clock); #1;
        c = cyc;
        d_req = 1; d_we = 0; d_addr = 32'h40;
        push_exp(1'b1, 1'b1, c + LATENCY, L4);
        repeat (2) @(posedge clock);
        #1 d_req = 0; d_we = 1; d_addr = 32'h100; d_wdata = '1;
        wait_ready(1'b1, c, 1'b1);
        @(posedge clock); #1 idle_inputs();
        do_txn(1'b0, 1'b0, 32'h100, '0, V5A, 1'b1); // not overwritten

        // Reset in the middle of a write to line 8: aborted, nothing committed.
        @(posedge clock); #1;
        c = cyc;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = V8B;
        repeat (3) @(posedge clock);
        #1 reset = 1; d_req = 0; d_we = 0;
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        check("abort_busy", {127'd0, busy}, 0);
        check("abort_d_ready", {127'd0, d_ready}, 0);
        check("abort_d_rdata", d_rdata, 0);
        got = 0;
        for (int n = 0; n < LATENCY + 2; n++) begin
            @(negedge clock);
            if (i_ready || d_ready) got = 1;
        end
        check("abort_no_ready", {127'd0, got}, 0);
        do_txn(1'b1, 1'b0, 32'h80, '0, V8, 1'b1);

        repeat (2) @(negedge clock);
        check("queue_empty", 128'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Main-memory responder at the far end of the cache-fill interface. It services line-sized read requests from the instruction-cache controller and read/write requests from the data-cache controller. It arbitrates between the two ports, models a fixed access latency with a counter, holds the backing line storage, and returns each response with a one-cycle ready pulse. It sits outside the pipeline, below both cache controllers. The controllers' stall outputs stay high until this block answers.

## Interface
Parameters:
- LINE_BITS, 128, line width in bits (4 × 32-bit words).
- ADDR_BITS, 32, request address width.
- LINES, 1024, number of stored lines (power of two).
- LATENCY, 5, cycles from request acceptance to ready pulse (≥2).

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- i_req  input  1  instruction-side line read request.
- i_addr  input  ADDR_BITS  instruction-side byte address.
- i_rdata  output  LINE_BITS  line returned to the I-side.
- i_ready  output  1  one-cycle pulse: I-side request complete.
- d_req  input  1  data-side request.
- d_we  input  1  data-side request is a line write (writeback).
- d_addr  input  ADDR_BITS  data-side byte address.
- d_wdata  input  LINE_BITS  data-side write line.
- d_rdata  output  LINE_BITS  line returned to the D-side.
- d_ready  output  1  one-cycle pulse: D-side request complete.
- busy  output  1  a transaction is in flight.

## Operation
- Line index = addr[log2(LINE_BITS/8) +: log2(LINES)]. Lower offset bits are ignored. Higher bits wrap modulo LINES.
- States and transitions:
  - IDLE: no transaction. If any request is pending, arbitrate, go to BUSY, latch grant/we/index/wdata, and load the counter with LATENCY-1.
  - BUSY: decrement the counter each cycle. At zero, go to RESP.
  - RESP: pulse the granted port's ready for one cycle. Perform the write if we, or drive the read line. Return to IDLE.
- Arbitration (default): fixed priority, D over I.
- Inputs are latched at acceptance. Changes to addr/wdata/we, or deassertion of req, during BUSY are ignored. The transaction still completes and ready still pulses.
- Requester protocol: hold req until ready, then deassert req in the cycle after ready unless issuing a new request. A req still high in IDLE is a new request.
- Write: storage is updated at the RESP clock edge. d_rdata in RESP is the old line (read-before-write).
- Read: rdata is valid only while the port's ready is high. Otherwise it holds its last value.
- The ungranted port waits. No request is lost while its req is held.
- Storage contents are unaffected by reset. Unwritten contents are X in simulation.

## Timing
- Reset values: i_ready=0, d_ready=0, busy=0, i_rdata=0, d_rdata=0. State = IDLE, counter = 0.
- A request sampled in IDLE at edge k gives ready high during cycle k+LATENCY (exactly one cycle).
- busy is high from cycle k+1 through the RESP cycle, inclusive.
- Back-to-back: after RESP, the earliest next acceptance is the following IDLE cycle. Throughput is one line per LATENCY+1 cycles.
- Simultaneous i_req and d_req in IDLE: D is granted. I is accepted in the next IDLE cycle if i_req is still high.
- Reset mid-transaction: abort and return to IDLE. No write is committed and no ready pulse is issued.
- ready is never asserted on both ports in the same cycle.

## Configuration
- Macro: MEM_LINE_RESPONDER_RR_EN.
- When defined: round-robin arbitration. A one-bit last-grant register is reset to I, so the first conflict grants D. On conflict the port not granted last wins. A single requester is always granted.
- When undefined: fixed D-over-I priority as above, and no last-grant register exists.

## Test plan
- Reset, then I-read of addr 0x40 (line 4 preloaded 0x…0004) with LATENCY=5. Accepted at edge 0: i_ready high only in cycle 5, i_rdata=line 4, busy high in cycles 1–5.
- D-write of 0xA5A5…A5A5 to 0x100, then D-read of 0x100. The read returns 0xA5A5…A5A5, and the write's d_rdata showed the old line.
- i_req and d_req asserted together and both held. Default: d_ready at cycle 5, i_ready at cycle 11. With RR_EN and two repeated conflicts: grants alternate D, I, D.
- addr 0x4040 with LINES=1024 aliases to line index 4 (wrap). It reads the same data as addr 0x40.
- Change d_addr and drop d_req at cycle 2 of BUSY. d_ready still pulses at cycle 5 with data from the originally latched address.
- Assert reset at cycle 3 of a D-write to line 8. No ready pulse, busy=0 next cycle, and a later read of line 8 returns the pre-write value.
